rca_sub_serial_14bit: RTL and testbench
=======================================

// Module: rca_sub_serial_14bit
// PURPOSE
//  Inverse of the 14-bit ripple-carry adder: recovers one addend from a (WIDTH+1)-bit sum and the other addend.
//  - o_diff = i_sum - i_term.
//  - Bit-serial ripple subtraction: one full-subtractor cell, one borrow flop, one bit per clock.
//  - valid/ready handshake on both sides.
//  - Sits downstream of the adder batch as a round-trip checker and decoder.
// PARAMETERS
//  WIDTH  14  addend width; i_sum and o_diff are WIDTH+1 bits, i_term is WIDTH bits
// PORTS
//  i_clk        in   1        clock; all state changes on the rising edge
//  i_rst        in   1        reset, synchronous, active-high
//  i_valid      in   1        operands valid
//  o_ready      out  1        block idle, can accept operands
//  i_sum        in   WIDTH+1  minuend (adder o_result format)
//  i_term       in   WIDTH    subtrahend (known addend)
//  o_valid      out  1        result valid, held until i_ready
//  i_ready      in   1        downstream accepts result
//  o_diff       out  WIDTH+1  i_sum - i_term, modulo 2^(WIDTH+1)
//  o_borrow     out  1        final borrow out (i_sum < i_term)
//  o_range_err  out  1        o_borrow | o_diff[WIDTH]: result is not a valid WIDTH-bit addend
// BEHAVIOUR
//  - Reset: state IDLE, bit counter 0, borrow 0.
//    All outputs 0 except o_ready=1. Reset mid-operation discards the operation in progress.
//  - Accept: an operation is accepted on the edge where i_valid & o_ready.
//    Accepting latches i_sum into a shift register, zero-extends i_term to WIDTH+1 bits, clears borrow, sets cnt=0, and moves to RUN.
//  - IDLE: o_ready=1, o_valid=0. Inputs are ignored unless i_valid is high.
//  - RUN: o_ready=0. On each edge:
//    - d = a0 ^ b0 ^ brw; brw' = (~a0 & b0) | (~(a0 ^ b0) & brw).
//    - Shift a and b right; shift d into the MSB of the result register; cnt++.
//    - When cnt==WIDTH is processed, go to DONE. RUN lasts WIDTH+1 cycles.
//  - DONE: o_valid=1. o_diff, o_borrow and o_range_err are stable and registered.
//    - i_ready=1: go to IDLE on that edge; o_valid drops the next cycle.
//    - i_ready low: hold all outputs indefinitely.
//  - Latency: o_valid is high after the (WIDTH+1)th edge following the accept edge (15 edges at WIDTH=14).
//  - Throughput: one operation per WIDTH+3 cycles, with one idle cycle after each handshake.
//  - o_ready=0 in both RUN and DONE, so no accept can coincide with a result handshake.
//  - i_valid/i_sum/i_term changes during RUN or DONE have no effect.
//  - Arithmetic wraps modulo 2^(WIDTH+1). Example: i_sum=0, i_term=1 -> o_diff=all ones, o_borrow=1.
// CONFIGURATION
//  RCA_SUB_SAT_EN
//   - defined: when o_borrow=1, o_diff is forced to 0 in DONE. o_borrow and o_range_err are unchanged.
//   - undefined: o_diff is the raw modulo result.
// STRUCTURE
//  - Package rca_pkg:
//    - rca_sub_state_t enum {IDLE, RUN, DONE}
//    - localparam RCA_DEFAULT_WIDTH = 14
//    - counter width function $clog2(WIDTH+1)
//  - Sub-module fs_1bit: combinational full-subtractor cell (a, b, bin -> d, bout).
//    Instantiated once and driven from the shift-register LSBs.
// TESTING
//  - Round trip: i_sum=15'd300, i_term=14'd100 ->
//    o_diff=15'd200, o_borrow=0, o_range_err=0; o_valid 15 edges after the accept edge.
//  - Borrow: i_sum=15'd5, i_term=14'd9 -> o_diff=15'h7FFC, o_borrow=1, o_range_err=1.
//    With RCA_SUB_SAT_EN: o_diff=0.
//  - Max range: i_sum=15'h7FFE, i_term=14'h3FFF -> o_diff=15'h3FFF, o_range_err=0.
//    i_sum=15'h4000, i_term=0 -> o_range_err=1.
//  - Backpressure: hold i_ready=0 for 10 cycles in DONE ->
//    o_valid and o_diff stable, o_ready=0, and i_valid pulses are ignored.
//  - Reset mid-RUN: assert i_rst at cnt=7 -> next cycle state IDLE, o_ready=1, o_valid=0.
//    A fresh op then gives the correct result.
//  - Randomized back-to-back ops vs. the golden model (i_sum - i_term) ->
//    every result matches; one idle cycle between the handshake and the next accept.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types and helpers for the bit-serial ripple subtractor.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_sub_state_t;

    localparam int unsigned RCA_DEFAULT_WIDTH = 14;

    // Bit counter width: must hold 0..width inclusive.
    function automatic int unsigned rca_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fs_1bit.sv
// Single combinational full-subtractor cell: d = a - b - bin.
module fs_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/rca_sub_serial_14bit.sv
// Bit-serial ripple subtractor: o_diff = i_sum - i_term, one bit per clock,
// valid/ready on both sides. Optional macro RCA_SUB_SAT_EN clamps o_diff to 0
// when the subtraction borrows.
module rca_sub_serial_14bit
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH:0]   i_sum,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_diff,
    output logic             o_borrow,
    output logic             o_range_err
);

    localparam int unsigned CW = rca_cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]       state_q;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   b_q;
    logic [WIDTH-1:0] res_q;

    logic             ready_q;
    logic             valid_q;
    logic [WIDTH:0]   diff_q;
    logic             borrow_q;
    logic             range_q;

    logic             accept;
    logic             last_bit;
    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH:0]   final_diff;

    assign accept   = (state_q == ST_IDLE) && i_valid;
    assign last_bit = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH));

    // The one subtractor cell, fed from the operand shift-register LSBs.
    fs_1bit u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

`ifdef RCA_SUB_SAT_EN
    assign final_diff = fs_bout ? '0 : {fs_d, res_q};
`else
    assign final_diff = {fs_d, res_q};
`endif

    // Next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: if (i_ready)  state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_next;
            ready_q <= (state_next == ST_IDLE);
            valid_q <= (state_next == ST_DONE);
        end
    end

    // Serial datapath: operand load on accept, one bit per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            brw_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            brw_q <= 1'b0;
            a_q   <= i_sum;
            b_q   <= {1'b0, i_term};
            res_q <= '0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + CW'(1);
            brw_q <= fs_bout;
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= {fs_d, res_q[WIDTH-1:1]};
        end
    end

    // Result registers, loaded as the final (MSB) bit is processed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
            range_q  <= 1'b0;
        end else if (last_bit) begin
            diff_q   <= final_diff;
            borrow_q <= fs_bout;
            range_q  <= fs_bout | fs_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_diff      = diff_q;
    assign o_borrow    = borrow_q;
    assign o_range_err = range_q;

endmodule

// File: tb/tb_rca_sub_serial_14bit.sv
// Self-checking bench for rca_sub_serial_14bit (honours RCA_SUB_SAT_EN).
module tb_rca_sub_serial_14bit;

    localparam int LAT    = 15;
    localparam int PERIOD = 17;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [14:0] i_sum;
    logic [13:0] i_term;
    logic        o_valid;
    logic        i_ready;
    logic [14:0] o_diff;
    logic        o_borrow;
    logic        o_range_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rca_sub_serial_14bit dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sum       (i_sum),
        .i_term      (i_term),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_diff      (o_diff),
        .o_borrow    (o_borrow),
        .o_range_err (o_range_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference model: plain integer subtraction, wrapped to 15 bits.
    function automatic logic [14:0] ref_diff(input logic [14:0] s, input logic [13:0] t);
        int x;
        logic [14:0] d;
        x = int'(s) - int'(t);
        d = 15'(x);
`ifdef RCA_SUB_SAT_EN
        if (x < 0) d = 15'd0;
`endif
        return d;
    endfunction

    function automatic logic ref_borrow(input logic [14:0] s, input logic [13:0] t);
        return int'(s) < int'(t);
    endfunction

    function automatic logic ref_range(input logic [14:0] s, input logic [13:0] t);
        int x;
        x = int'(s) - int'(t);
        return (x < 0) || (x >= 16384);
    endfunction

    // Drive one operation and collect its result; optionally complete the handshake.
    task automatic do_op(input logic [14:0] s, input logic [13:0] t, input bit rel,
                         output logic [14:0] d, output logic b, output logic r,
                         output int lat, output int acc);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        i_sum   = s;
        i_term  = t;
        i_valid = 1'b1;
        @(posedge i_clk);
        acc = cyc;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_sum   = 15'($urandom);
        i_term  = 14'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        d = o_diff;
        b = o_borrow;
        r = o_range_err;
        if (rel) begin
            i_ready = 1'b1;
            @(negedge i_clk);
            i_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_sum = '0;
        i_term = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_diff, o_borrow, o_range_err} !== {1'b1, 1'b0, 15'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b valid=%b diff=%h borrow=%b range=%b, want ready=1 valid=0 diff=0000 borrow=0 range=0",
                     o_ready, o_valid, o_diff, o_borrow, o_range_err);
        end
    endtask

    task automatic test_directed();
        logic [14:0] ss [4];
        logic [13:0] tt [4];
        logic [14:0] d;
        logic b, r;
        int lat, acc;
        ss[0] = 15'd300;   tt[0] = 14'd100;
        ss[1] = 15'd5;     tt[1] = 14'd9;
        ss[2] = 15'h7FFE;  tt[2] = 14'h3FFF;
        ss[3] = 15'h4000;  tt[3] = 14'h0;
        for (int i = 0; i < 4; i++) begin
            do_op(ss[i], tt[i], 1'b1, d, b, r, lat, acc);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d edges, want %0d", i, lat, LAT);
            end
            checks++;
            if ({d, b, r} !== {ref_diff(ss[i], tt[i]), ref_borrow(ss[i], tt[i]), ref_range(ss[i], tt[i])}) begin
                failures++;
                $display("FAIL dir%0d_result: got diff=%h borrow=%b range=%b, want diff=%h borrow=%b range=%b",
                         i, d, b, r, ref_diff(ss[i], tt[i]), ref_borrow(ss[i], tt[i]), ref_range(ss[i], tt[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] d, s;
        logic [13:0] t;
        logic b, r;
        int lat, acc;
        s = 15'h1234;
        t = 14'h0FF0;
        do_op(s, t, 1'b0, d, b, r, lat, acc);
        for (int i = 0; i < 10; i++) begin
            i_valid = i[0];
            i_sum   = 15'($urandom);
            i_term  = 14'($urandom);
            @(negedge i_clk);
            checks++;
            if ({o_valid, o_ready, o_diff} !== {1'b1, 1'b0, ref_diff(s, t)}) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b diff=%h, want valid=1 ready=0 diff=%h",
                         i, o_valid, o_ready, o_diff, ref_diff(s, t));
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: got valid=%b ready=%b, want valid=0 ready=1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [14:0] d;
        logic b, r;
        int lat, acc;
        i_sum   = 15'h7000;
        i_term  = 14'h0001;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (6) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            failures++;
            $display("FAIL midrun_reset: got ready=%b valid=%b, want ready=1 valid=0", o_ready, o_valid);
        end
        do_op(15'd1000, 14'd999, 1'b1, d, b, r, lat, acc);
        checks++;
        if ({d, b, r, lat} !== {15'd1, 1'b0, 1'b0, LAT}) begin
            failures++;
            $display("FAIL midrun_fresh: got diff=%h borrow=%b range=%b lat=%0d, want diff=0001 borrow=0 range=0 lat=%0d",
                     d, b, r, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] d, s;
        logic [13:0] t;
        logic b, r;
        int lat, acc, prev_acc;
        prev_acc = -1;
        for (int i = 0; i < 24; i++) begin
            s = 15'($urandom);
            t = 14'($urandom);
            if (i % 6 == 0) s = 15'(t);
            if (i % 6 == 1) s = 15'($urandom_range(0, 31));
            do_op(s, t, 1'b1, d, b, r, lat, acc);
            checks++;
            if ({d, b, r} !== {ref_diff(s, t), ref_borrow(s, t), ref_range(s, t)}) begin
                failures++;
                $display("FAIL b2b%0d_result: s=%h t=%h got diff=%h borrow=%b range=%b, want diff=%h borrow=%b range=%b",
                         i, s, t, d, b, r, ref_diff(s, t), ref_borrow(s, t), ref_range(s, t));
            end
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL b2b%0d_latency: got %0d, want %0d", i, lat, LAT);
            end
            checks++;
            if ({o_valid, o_ready} !== 2'b01) begin
                failures++;
                $display("FAIL b2b%0d_post_hs: got valid=%b ready=%b, want valid=0 ready=1", i, o_valid, o_ready);
            end
            if (prev_acc >= 0) begin
                checks++;
                if (acc - prev_acc !== PERIOD) begin
                    failures++;
                    $display("FAIL b2b%0d_period: got %0d cycles, want %0d", i, acc - prev_acc, PERIOD);
                end
            end
            prev_acc = acc;
        end
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
